// File: rtl/alloc_dispatcher.sv
// Alloc dispatcher: buffers client alloc requests, maps each byte count to a size class and
// issues the requests one at a time to the find table. A head rejected as blocked is kept and
// replayed on a find-table update or after a retry timeout. Illegal sizes are reported on the
// error port and never buffered.

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 2
`endif
`ifndef REQ_512
`define REQ_512 2'd0
`endif
`ifndef REQ_1K
`define REQ_1K 2'd1
`endif
`ifndef REQ_2K
`define REQ_2K 2'd2
`endif
`ifndef REQ_4K
`define REQ_4K 2'd3
`endif

module alloc_dispatcher #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned RETRY_TIMEOUT = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid_in,
   output logic                            req_ready_out,
   input  logic [`REQ_ID_WIDTH-1:0]        req_id_in,
   input  logic [12:0]                     req_bytes_in,
   output logic                            alloc_valid_dsp_out,
   output logic [`REQ_ID_WIDTH-1:0]        alloc_id_dsp_out,
   output logic [`REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_dsp_out,
   input  logic                            fdt_blocked_in,
   input  logic                            fdt_update_valid_in,
   output logic                            err_valid_out,
   output logic [`REQ_ID_WIDTH-1:0]        err_id_out,
   output logic                            busy_out
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned IdW  = `REQ_ID_WIDTH;
   localparam int unsigned SzW  = `REQ_SIZE_TYPE_WIDTH;

   localparam logic [CntW-1:0] DepthCnt  = CntW'(FIFO_DEPTH);
   localparam logic [7:0]      RetryLast = 8'(RETRY_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StBlocked} state_e;

   typedef struct packed {
      logic [IdW-1:0] id;
      logic [SzW-1:0] cls;
   } entry_t;

   state_e          state_q;
   logic [7:0]      retry_cnt_q;

   entry_t          mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW-1:0] rd_ptr_nxt;
   logic [CntW-1:0] count_q;

   logic            alloc_valid_q;
   logic [IdW-1:0]  alloc_id_q;
   logic [SzW-1:0]  alloc_size_q;
   logic            err_valid_q;
   logic [IdW-1:0]  err_id_q;

   logic            req_legal;
   logic [SzW-1:0]  req_class;
   logic            req_accept;
   logic            fifo_push;
   logic            fifo_pop;
   entry_t          head;
   entry_t          head_nxt;

   // Classify the incoming byte count into a size class and flag illegal sizes
   always_comb begin
      req_legal = (req_bytes_in != 13'd0) && (req_bytes_in <= 13'd4096);
      if (req_bytes_in <= 13'd512) begin
         req_class = `REQ_512;
      end else if (req_bytes_in <= 13'd1024) begin
         req_class = `REQ_1K;
      end else if (req_bytes_in <= 13'd2048) begin
         req_class = `REQ_2K;
      end else begin
         req_class = `REQ_4K;
      end
   end

   assign req_ready_out = (count_q < DepthCnt);
   assign req_accept    = req_valid_in && req_ready_out;
   assign fifo_push     = req_accept && req_legal;
   // The head leaves the buffer only once the find table has taken it without blocking
   assign fifo_pop      = (state_q == StWait) && !fdt_blocked_in;
   assign rd_ptr_nxt    = rd_ptr_q + 1'b1;
   assign head          = mem_q[rd_ptr_q];
   assign head_nxt      = mem_q[rd_ptr_nxt];

   // Request storage; left unreset because count_q gates every read
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         mem_q[wr_ptr_q] <= '{id: req_id_in, cls: req_class};
      end
   end

   // FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr_q <= rd_ptr_nxt;
         end
         case ({fifo_push, fifo_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Dispatch FSM with registered issue outputs; the issued id/class hold between issues
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         retry_cnt_q   <= '0;
         alloc_valid_q <= 1'b0;
         alloc_id_q    <= '0;
         alloc_size_q  <= '0;
      end else begin
         alloc_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (count_q != '0) begin
                  state_q       <= StIssue;
                  alloc_valid_q <= 1'b1;
                  alloc_id_q    <= head.id;
                  alloc_size_q  <= head.cls;
               end
            end
            StIssue: begin
               state_q <= StWait;
            end
            StWait: begin
               if (fdt_blocked_in) begin
                  state_q     <= StBlocked;
                  retry_cnt_q <= '0;
               end else if (count_q > CntW'(1)) begin
                  // Head is popped this cycle, so the next issue takes the entry behind it
                  state_q       <= StIssue;
                  alloc_valid_q <= 1'b1;
                  alloc_id_q    <= head_nxt.id;
                  alloc_size_q  <= head_nxt.cls;
               end else begin
                  state_q <= StIdle;
               end
            end
            StBlocked: begin
               if (fdt_update_valid_in || (retry_cnt_q == RetryLast)) begin
                  state_q       <= StIssue;
                  retry_cnt_q   <= '0;
                  alloc_valid_q <= 1'b1;
                  alloc_id_q    <= head.id;
                  alloc_size_q  <= head.cls;
               end else begin
                  retry_cnt_q <= retry_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Error pulse for an accepted request of illegal size; the id holds until the next error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_valid_q <= 1'b0;
         err_id_q    <= '0;
      end else begin
         err_valid_q <= req_accept && !req_legal;
         if (req_accept && !req_legal) begin
            err_id_q <= req_id_in;
         end
      end
   end

   assign alloc_valid_dsp_out = alloc_valid_q;
   assign alloc_id_dsp_out    = alloc_id_q;
   assign alloc_size_dsp_out  = alloc_size_q;
   assign err_valid_out       = err_valid_q;
   assign err_id_out          = err_id_q;
   // Every non-idle state still holds its head in the buffer
   assign busy_out            = (count_q != '0) || (state_q != StIdle);

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_push && !fifo_pop && (count_q == DepthCnt)));
   a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_pop |-> (count_q != '0));
`endif

endmodule

// File: tb/tb_alloc_dispatcher.sv
// Scoreboard bench for alloc_dispatcher: the driver pushes expected issues and errors into
// queues, and a monitor derives the expected issue timing from a request-level model.

module tb_alloc_dispatcher;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic       clk;
   logic       rst_n;
   logic       req_valid_in;
   logic       req_ready_out;
   logic [7:0] req_id_in;
   logic [12:0] req_bytes_in;
   logic       alloc_valid_dsp_out;
   logic [7:0] alloc_id_dsp_out;
   logic [1:0] alloc_size_dsp_out;
   logic       fdt_blocked_in;
   logic       fdt_update_valid_in;
   logic       err_valid_out;
   logic [7:0] err_id_out;
   logic       busy_out;

   alloc_dispatcher #(
      .FIFO_DEPTH   (DEPTH),
      .RETRY_TIMEOUT(TIMEOUT)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid_in       (req_valid_in),
      .req_ready_out      (req_ready_out),
      .req_id_in          (req_id_in),
      .req_bytes_in       (req_bytes_in),
      .alloc_valid_dsp_out(alloc_valid_dsp_out),
      .alloc_id_dsp_out   (alloc_id_dsp_out),
      .alloc_size_dsp_out (alloc_size_dsp_out),
      .fdt_blocked_in     (fdt_blocked_in),
      .fdt_update_valid_in(fdt_update_valid_in),
      .err_valid_out      (err_valid_out),
      .err_id_out         (err_id_out),
      .busy_out           (busy_out)
   );

   typedef struct {
      logic [7:0] id;
      logic [1:0] cls;
      int         acc;
   } iss_t;

   typedef struct {
      logic [7:0] id;
      int         acc;
   } err_t;

   iss_t iss_q[$];
   err_t err_q[$];

   int cyc;
   int n_checks;
   int n_errors;
   bit fdt_manual;
   int blk_pct;
   int upd_pct;

   // Monitor-side model state
   bit         inflight;
   bit         blocked;
   int         issue_cyc;
   int         replay_due;
   int         last_pop;
   logic [7:0] last_id;
   logic [1:0] last_size;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Size class = log2 of the number of 512-byte blocks, rounded up
   function automatic logic [1:0] size_class(input int bytes);
      int blocks;
      blocks = (bytes + 511) / 512;
      return 2'($clog2(blocks));
   endfunction

   function automatic bit is_legal(input int bytes);
      return (bytes >= 1) && (bytes <= 4096);
   endfunction

   function automatic logic [12:0] rand_bytes();
      int sel;
      int k;
      int b;
      sel = $urandom_range(0, 9);
      case (sel)
         0: return 13'd0;
         1: return 13'($urandom_range(4097, 8191));
         2: begin
            k = $urandom_range(0, 3);
            b = 512 << k;
            if (k < 3 && $urandom_range(0, 1) == 1) b = b + 1;
            return 13'(b);
         end
         3: return 13'd1;
         default: return 13'($urandom_range(1, 4096));
      endcase
   endfunction

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
   task automatic send(input logic [7:0] id, input logic [12:0] bytes);
      int   guard;
      iss_t ie;
      err_t ee;
      guard = 0;
      req_valid_in = 1'b1;
      req_id_in    = id;
      req_bytes_in = bytes;
      forever begin
         @(negedge clk);
         if (req_ready_out) break;
         guard++;
         if (guard > 3000) begin
            chk("req_ready_wait", int'(req_ready_out), 1);
            break;
         end
      end
      if (req_ready_out) begin
         if (is_legal(int'(bytes))) begin
            ie.id  = id;
            ie.cls = size_class(int'(bytes));
            ie.acc = cyc;
            iss_q.push_back(ie);
         end else begin
            ee.id  = id;
            ee.acc = cyc;
            err_q.push_back(ee);
         end
      end
      @(posedge clk);
      #1;
      req_valid_in = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_alloc_valid"}, int'(alloc_valid_dsp_out), 0);
      chk({tag, "_alloc_id"}, int'(alloc_id_dsp_out), 0);
      chk({tag, "_alloc_size"}, int'(alloc_size_dsp_out), 0);
      chk({tag, "_err_valid"}, int'(err_valid_out), 0);
      chk({tag, "_err_id"}, int'(err_id_out), 0);
      chk({tag, "_busy"}, int'(busy_out), 0);
      chk({tag, "_ready"}, int'(req_ready_out), 1);
   endtask

   // Random find-table behaviour when the directed sequences are not driving it
   initial begin : fdt_drv
      forever begin
         @(posedge clk);
         #1;
         if (!fdt_manual) begin
            fdt_blocked_in      = ($urandom_range(99) < blk_pct);
            fdt_update_valid_in = ($urandom_range(99) < upd_pct);
         end
      end
   end

   // Monitor: compares every cycle against the request-level model
   initial begin : monitor
      int n_held;
      int exp_cyc;
      bit exp_valid;
      bit exp_err;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            iss_q.delete();
            err_q.delete();
            inflight  = 1'b0;
            blocked   = 1'b0;
            last_pop  = -100;
            last_id   = '0;
            last_size = '0;
         end else begin
            n_held = 0;
            foreach (iss_q[i]) if (iss_q[i].acc < cyc) n_held++;
            chk("req_ready", int'(req_ready_out), int'(n_held < DEPTH));
            chk("busy", int'(busy_out), int'(n_held != 0));

            exp_cyc = -1;
            if (!inflight && iss_q.size() > 0) begin
               exp_cyc = blocked ? replay_due : max2(iss_q[0].acc + 2, last_pop + 1);
            end
            exp_valid = (exp_cyc == cyc);
            chk("alloc_valid", int'(alloc_valid_dsp_out), int'(exp_valid));
            if (alloc_valid_dsp_out && !inflight && iss_q.size() > 0) begin
               chk("alloc_id", int'(alloc_id_dsp_out), int'(iss_q[0].id));
               chk("alloc_size", int'(alloc_size_dsp_out), int'(iss_q[0].cls));
               inflight  = 1'b1;
               blocked   = 1'b0;
               issue_cyc = cyc;
               last_id   = iss_q[0].id;
               last_size = iss_q[0].cls;
            end else if (!alloc_valid_dsp_out) begin
               chk("alloc_id_hold", int'(alloc_id_dsp_out), int'(last_id));
               chk("alloc_size_hold", int'(alloc_size_dsp_out), int'(last_size));
            end

            if (blocked && fdt_update_valid_in && cyc < replay_due) replay_due = cyc + 1;

            if (inflight && cyc == issue_cyc + 1) begin
               inflight = 1'b0;
               if (fdt_blocked_in) begin
                  blocked    = 1'b1;
                  replay_due = cyc + 1 + TIMEOUT;
               end else begin
                  iss_q.delete(0);
                  last_pop = cyc;
               end
            end

            exp_err = (err_q.size() > 0) && (err_q[0].acc + 1 == cyc);
            chk("err_valid", int'(err_valid_out), int'(exp_err));
            if (exp_err) begin
               chk("err_id", int'(err_id_out), int'(err_q[0].id));
               err_q.delete(0);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
               n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int guard;
      int gap;
      n_checks            = 0;
      n_errors            = 0;
      fdt_manual          = 1'b1;
      blk_pct             = 0;
      upd_pct             = 0;
      rst_n               = 1'b0;
      req_valid_in        = 1'b0;
      req_id_in           = '0;
      req_bytes_in        = '0;
      fdt_blocked_in      = 1'b0;
      fdt_update_valid_in = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single request, find table never blocks
      send(8'd5, 13'd700);
      repeat (6) @(posedge clk);
      #1;

      // Back-to-back requests covering class boundaries
      send(8'd11, 13'd1);
      send(8'd12, 13'd512);
      send(8'd13, 13'd2048);
      send(8'd14, 13'd4096);
      repeat (10) @(posedge clk);
      #1;

      // Illegal sizes
      send(8'd3, 13'd0);
      send(8'd4, 13'd5000);
      repeat (5) @(posedge clk);
      #1;

      // Blocked head released by an update pulse; buffer fills while blocked
      fdt_blocked_in = 1'b1;
      send(8'd7, 13'd100);
      send(8'd8, 13'd1500);
      send(8'd9, 13'd3000);
      send(8'd10, 13'd20);
      repeat (8) @(posedge clk);
      #1;
      fdt_update_valid_in = 1'b1;
      @(posedge clk);
      #1;
      fdt_update_valid_in = 1'b0;
      fdt_blocked_in      = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // Blocked head replayed on retry timeout
      fdt_blocked_in = 1'b1;
      send(8'd30, 13'd3000);
      repeat (3) @(posedge clk);
      #1;
      fdt_blocked_in = 1'b0;
      repeat (75) @(posedge clk);
      #1;

      // Reset while blocked with three entries buffered
      fdt_blocked_in = 1'b1;
      send(8'd20, 13'd600);
      send(8'd21, 13'd1200);
      send(8'd22, 13'd2400);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n          = 1'b1;
      fdt_blocked_in = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      send(8'd23, 13'd64);
      repeat (6) @(posedge clk);
      #1;

      // Randomised traffic with random blocking and updates
      fdt_manual = 1'b0;
      blk_pct    = 20;
      upd_pct    = 10;
      for (int t = 0; t < 300; t++) begin
         send(8'($urandom_range(255)), rand_bytes());
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end

      // Drain with the find table unblocked
      blk_pct = 0;
      guard   = 0;
      while ((iss_q.size() > 0 || err_q.size() > 0) && guard < 4000) begin
         @(posedge clk);
         guard++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("drain_issue_q", iss_q.size(), 0);
      chk("drain_err_q", err_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
